// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes and the hazard scoreboard entry.
// Also holds the hit test that compares one source register against one entry.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    // x0 is hardwired, so it can never be the source of a real dependency.
    function automatic logic sb_hit(input sb_entry_t entry, input logic [4:0] rs);
        return entry.valid && (entry.rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/rv32i_hazard_ctrl_if.sv
// Bus between the pipeline datapath (master) and the hazard controller (slave).
interface rv32i_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             id_valid;
    logic [31:0]      id_iw;
    logic             ex_redirect;
    logic             stall;
    logic             bubble_ex;
    logic             flush_id;
    logic             pc_redirect;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_iw, ex_redirect,
        input  stall, bubble_ex, flush_id, pc_redirect, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_iw, ex_redirect,
        output stall, bubble_ex, flush_id, pc_redirect, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/rv32i_reg_use.sv
// Combinational register-usage decode for one RV32I instruction word.
module rv32i_reg_use
    import rv32i_pkg::*;
(
    input  logic [31:0] iw,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic        writes_rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);
    logic unused_funct;

    assign rs1 = iw[19:15];
    assign rs2 = iw[24:20];
    assign rd  = iw[11:7];
    assign unused_funct = ^{iw[31:25], iw[14:12]};

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        case (iw[6:0])
            OP_R: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Stall/bubble/flush sequencing for the non-forwarding 5-stage RV32I pipeline,
// with saturating stall-cycle and redirect-event counters.
module rv32i_hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter bit          WB_WRITE_THROUGH = 1'b1,
    parameter int unsigned CNT_W            = 32
) (
    input logic               clk,
    input logic               reset,
    rv32i_hazard_ctrl_if.slave bus
);
    logic       use_rs1, use_rs2, writes_rd;
    logic [4:0] rs1, rs2, rd;

    sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q, sb_ex_d;
    logic      rs1_hit, rs2_hit, hazard;
    logic      stall, bubble_ex, flush_id, pc_redirect;

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    rv32i_reg_use u_reg_use (
        .iw       (bus.id_iw),
        .use_rs1  (use_rs1),
        .use_rs2  (use_rs2),
        .writes_rd(writes_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd)
    );

    // With a write-before-read register file the WB producer is already visible.
    always_comb begin
        rs1_hit = use_rs1 && (sb_hit(sb_ex_q, rs1) || sb_hit(sb_mem_q, rs1) ||
                              (!WB_WRITE_THROUGH && sb_hit(sb_wb_q, rs1)));
        rs2_hit = use_rs2 && (sb_hit(sb_ex_q, rs2) || sb_hit(sb_mem_q, rs2) ||
                              (!WB_WRITE_THROUGH && sb_hit(sb_wb_q, rs2)));
        hazard  = bus.id_valid && (rs1_hit || rs2_hit);
    end

    always_comb begin
        stall       = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        pc_redirect = 1'b0;
        if (!reset) begin
            if (bus.ex_redirect) begin
                bubble_ex   = 1'b1;
                flush_id    = 1'b1;
                pc_redirect = 1'b1;
            end else if (hazard) begin
                stall     = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_comb begin
        sb_ex_d.valid = bus.id_valid && !bubble_ex && writes_rd && (rd != 5'd0);
        sb_ex_d.rd    = rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_ex_q  <= '0;
            sb_mem_q <= '0;
            sb_wb_q  <= '0;
        end else begin
            sb_ex_q  <= sb_ex_d;
            sb_mem_q <= sb_ex_q;
            sb_wb_q  <= sb_mem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bus.ex_redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall       = stall;
    assign bus.bubble_ex   = bubble_ex;
    assign bus.flush_id    = flush_id;
    assign bus.pc_redirect = pc_redirect;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: doc/rv32i_hazard_ctrl.md
# rv32i_hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core (IF, ID, EX, MEM, WB), which has no operand forwarding. It tracks destination registers in flight in EX, MEM and WB, and detects read-after-write hazards for the instruction in ID. It stalls the front end and injects bubbles into EX, and on a redirect resolved in EX it flushes the younger instructions. Two saturating performance counters record stall cycles and flush events.

## Interface
- WB_WRITE_THROUGH, default 1: 1 = register file write-before-read, so the WB entry is excluded from hazard checks.
- CNT_W, default 32: performance counter width.

- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- id_valid  input  1  ID holds a real instruction
- id_iw  input  32  instruction word in ID
- ex_redirect  input  1  EX resolved a taken branch, JAL or JALR this cycle
- stall  output  1  hold PC and the IF/ID register
- bubble_ex  output  1  load a NOP into the ID/EX register
- flush_id  output  1  load a NOP into the IF/ID register
- pc_redirect  output  1  select the EX target as next PC
- stall_cnt  output  CNT_W  stall cycles counted
- flush_cnt  output  CNT_W  redirect events counted

## Operation
- Register use is decoded from opcode id_iw[6:0]:
  - 0110011: uses rs1 and rs2, writes rd.
  - 0010011, 0000011, 1100111: uses rs1, writes rd.
  - 0100011 and 1100011: use rs1 and rs2, no rd.
  - 0110111, 0010111, 1101111: write rd only.
  - Any other opcode: uses nothing.
- Register x0 is never a hazard source and never a hazard destination.
- Scoreboard has three entries, sb_ex, sb_mem and sb_wb, each holding {valid, rd}. An entry is valid only if the instruction writes rd and rd != 0.
- hazard = id_valid AND a used, nonzero rs1 or rs2 equals rd of a valid sb_ex or sb_mem entry. The sb_wb entry is also checked when WB_WRITE_THROUGH = 0.
- Priority: ex_redirect beats hazard.
  - When ex_redirect = 1: pc_redirect = 1, flush_id = 1, bubble_ex = 1, stall = 0.
  - Otherwise, when hazard = 1: stall = 1, bubble_ex = 1, flush_id = 0, pc_redirect = 0.
  - Otherwise all four control outputs are 0.
- Scoreboard update, every cycle when not in reset:
  - sb_wb <= sb_mem and sb_mem <= sb_ex.
  - sb_ex <= invalid if bubble_ex = 1 or id_valid = 0; otherwise it takes the decoded {writes_rd, rd} from ID.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments on each cycle with ex_redirect = 1.
  - Both saturate at all-ones and never wrap.
- Reset:
  - All scoreboard entries become invalid and both counters become 0.
  - During a reset cycle, stall, bubble_ex, flush_id and pc_redirect are forced to 0 regardless of inputs.
  - Reset asserted mid-stall drops the stall in that same cycle.

## Timing
- stall, bubble_ex, flush_id and pc_redirect are combinational from id_iw, id_valid, ex_redirect and the registered scoreboard. They take effect in the current cycle (zero latency).
- The scoreboard and counters are registered and update on posedge clk.
- Dependency on the immediately preceding instruction, with WB_WRITE_THROUGH = 1:
  - The producer occupies EX, then MEM, then WB, so the consumer in ID sees 2 stall cycles.
  - With WB_WRITE_THROUGH = 0 it sees 3.
- A dependency separated by one independent instruction stalls 1 cycle. Separated by two, it stalls 0 (or 1 when WB_WRITE_THROUGH = 0).
- While stalled, the same ID instruction is re-evaluated each cycle. Stall deasserts in the cycle after the producer leaves the checked window.
- A redirect coinciding with a hazard produces no stall cycle, and stall_cnt does not increment. The two squashed instructions enter the scoreboard as invalid.
- Back-to-back redirects on consecutive cycles each count and each flush.

## Structure
- Shared package rv32i_pkg holds:
  - opcode localparams OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - typedef sb_entry_t {logic valid; logic [4:0] rd;}.
- Sub-module rv32i_reg_use: purely combinational, id_iw -> {use_rs1, use_rs2, writes_rd, rs1, rs2, rd}. It is reusable by the decode stage.

## Test plan
- Dependent ADDs: issue ADD x5,x1,x2, then ADD x6,x5,x3 next cycle (WB_WRITE_THROUGH=1) -> stall=1 and bubble_ex=1 for exactly 2 cycles, then 0; stall_cnt=2.
- x0 cases: ADDI x0,x1,1 followed by ADD x7,x0,x0 -> no stall. The scoreboard never marks an entry valid for rd=0.
- Store and branch have no rd: SW x5,0(x1), then ADD x1,x5,x5 -> no stall. Separately, BEQ followed by a reader of any register -> no hazard from the branch.
- Redirect overrides stall: a hazard is pending and ex_redirect=1 in the same cycle -> pc_redirect=flush_id=bubble_ex=1, stall=0, flush_cnt=1, stall_cnt unchanged.
- Reset mid-stall: assert reset during the 1st stall cycle -> all outputs 0 that cycle. After release, the old dependency no longer stalls and the counters read 0.
- Saturation: CNT_W=4, hold a hazard for 20 cycles -> stall_cnt stops at 15.
